pri_arbiter: RTL and testbench
==============================

Name: pri_arbiter

Overview:
- Parametrised, registered N-way arbiter and the successor of the team's combinational 4:2 priority encoder.
- Selects one requester in one of two modes: fixed priority, where the highest index wins, or rotating round-robin.
- Holds the grant until the requester acks or withdraws, then re-arbitrates back-to-back.
- Sits between N request sources and one shared resource (bus, port, FIFO write side).

Parameters:
- N, 8, number of requesters (N >= 2).
- W, $clog2(N), width of the grant index (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  N  request vector; bit i = requester i wants the resource.
- mode  input  1  0 = fixed priority (MSB highest), 1 = round-robin; sampled only when a new winner is chosen.
- ack  input  1  resource consumer finished with the current grant; meaningful only while valid=1.
- gnt  output  N  one-hot grant, registered.
- gnt_idx  output  W  binary index of the granted requester, registered.
- valid  output  1  a grant is active, registered (equivalent to the old encoder's valid).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - gnt=0, gnt_idx=0, valid=0, state=IDLE, ptr=N-1.
  - Reset overrides req and ack in the same cycle.
  - Reset during an active grant drops it at that edge; there is no completion.
- Internal ptr (W bits) is the highest-priority index for round-robin search. The search scans downward from ptr and wraps N-1 after 0.
- Fixed mode always searches from N-1, so it matches the old encoder's priority ordering.
- ptr is updated on every new grant in either mode: ptr = (winner - 1) mod N, with winner 0 giving ptr = N-1.
- State IDLE:
  - If |req, load the winner into gnt, gnt_idx and valid=1 at the next edge, then go to GRANT.
  - Latency: req sampled at edge t, grant visible after edge t+1.
  - Otherwise stay in IDLE with outputs 0.
- State GRANT:
  - Release condition: ack=1, or req[gnt_idx]=0 (withdrawal). Ack and withdrawal in the same cycle count as one release.
  - No release: hold all outputs stable. Changes to mode or to other req bits have no effect.
  - Release: arbitrate over req with the released requester's bit masked.
    - Some bit remains: the new winner is loaded at that same edge (no bubble) and the state stays GRANT.
    - No bit remains: valid=0, gnt=0, gnt_idx=0, go to IDLE.
  - The masked requester can win again from IDLE on the following cycle, so a sole requester sees one bubble cycle per grant.
- ack while valid=0 is ignored.
- Fixed mode: a lower-index requester can starve. This is intentional and documented.
- Round-robin mode with all bits requesting: grants cycle N-1, N-2, …, 0, N-1 with no bubbles.
- Invariants:
  - gnt is zero or one-hot.
  - gnt[gnt_idx] == valid.
  - gnt is never non-zero when valid=0.

Decomposition:
- Shared package pri_arb_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - State encoding ST_IDLE=1'b0, ST_GRANT=1'b1.
- One natural sub-module, pri_rotate_enc (combinational):
  - Inputs: req[N-1:0], start[W-1:0].
  - Outputs: idx[W-1:0], found.
  - Descending search from start with wrap, implemented by a double-width vector rotate.
  - The top level instantiates one pri_rotate_enc. Its start input is N-1 in fixed mode and ptr in round-robin mode; its req input is the masked request vector.

Test Plan:
- Reset: rst_n=0 with req=8'hFF for 2 cycles → gnt=0, valid=0, gnt_idx=0. Release reset, mode=0 → after 1 edge gnt_idx=7, gnt=8'h80, valid=1.
- Fixed priority: mode=0, req=8'b0101_0010 held, ack=1 every grant cycle → gnt_idx sequence 6, 4, 6, 4 with no bubbles; idx 1 is never granted.
- Round-robin: mode=1, req=8'hFF held, ack=1 continuously → gnt_idx 7,6,5,4,3,2,1,0,7 on consecutive cycles with valid=1 throughout.
- Withdrawal and empty:
  - Grant at idx 3, then req changes to 8'b0000_0001 → next edge gnt_idx=0, gnt=8'h01.
  - Then req=0 → next edge valid=0, gnt=0, and IDLE is entered.
  - Sole requester 2 with ack every cycle → valid toggles 1,0,1,0.
- Mode change mid-grant: mode=0, grant held at idx 5 with ack=0, mode switched to 1 → gnt stays 8'h20 until ack. Next winner uses round-robin from ptr=4.
- Reset mid-operation: round-robin grant at idx 2 (ptr=1), rst_n=0 for 1 cycle with req=8'hFF → outputs 0 at that edge. After release, first grant idx=7, confirming ptr was restored to N-1.

Source files
------------

// File: rtl/pri_arb_pkg.sv
// Shared definitions for the registered N-way priority / round-robin arbiter.
// The arbiter top, its rotate encoder and the invariant checker all import this package.
package pri_arb_pkg;

  // Arbitration mode, sampled only when a new winner is chosen.
  localparam logic MODE_FIXED = 1'b0;  // highest index always wins
  localparam logic MODE_RR    = 1'b1;  // search starts at the rotating pointer

  // Controller state: either no grant is active or one requester owns the resource.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage : pri_arb_pkg

// File: rtl/pri_arbiter_chk.sv
// Invariant checker for pri_arbiter outputs: grant is zero or one-hot, the indexed
// grant bit always equals valid, and no grant is driven without valid.
module pri_arbiter_chk
  import pri_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input logic         clk,
  input logic         rst_n,
  input logic [N-1:0] gnt,
  input logic [W-1:0] gnt_idx,
  input logic         valid
);

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
    else $error("pri_arbiter invariant violated: gnt=%h not zero/one-hot", gnt);

  a_idx_matches_valid: assert property (@(posedge clk) disable iff (!rst_n) gnt[gnt_idx] == valid)
    else $error("pri_arbiter invariant violated: gnt[%0d]=%b valid=%b", gnt_idx, gnt[gnt_idx], valid);

  a_no_gnt_without_valid: assert property (@(posedge clk) disable iff (!rst_n) valid || (gnt == {N{1'b0}}))
    else $error("pri_arbiter invariant violated: gnt=%h while valid=0", gnt);

endmodule : pri_arbiter_chk

// File: rtl/pri_rotate_enc.sv
// Combinational descending priority search with wrap-around.
// Searches req from bit 'start' downward, wrapping from 0 to N-1, and returns the
// first set bit. The search order is produced by rotating a doubled request vector
// so that bit 'start' lands on the MSB, then a plain MSB-first priority scan is used.
module pri_rotate_enc
  import pri_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  // N as a (W+1)-bit value, used to fold the rotated position back into 0..N-1.
  localparam logic [W:0] N_EXT = (W+1)'(N);
  localparam logic [W:0] ONE_EXT = {{W{1'b0}}, 1'b1};

  logic [N-1:0] rot_s;   // rot_s[j] = req[(j + start + 1) mod N]; rot_s[N-1] = req[start]
  logic [W-1:0] hit_s;   // position of the highest set bit in rot_s
  logic [W:0]   sum_s;   // hit_s + start + 1 before the modulo fold

  // Rotate, scan MSB-first, then map the rotated position back to a requester index.
  always_comb begin
    rot_s = N'({req, req} >> ({1'b0, start} + ONE_EXT));
    found = |rot_s;

    // Ascending loop: the last set bit seen is the highest one, i.e. the winner.
    hit_s = {W{1'b0}};
    for (int j = 0; j < N; j++) begin
      if (rot_s[j]) begin
        hit_s = W'(j);
      end else begin
        hit_s = hit_s;
      end
    end

    // hit_s + start + 1 is at most 2N-1, so one conditional subtraction suffices.
    sum_s = {1'b0, hit_s} + {1'b0, start} + ONE_EXT;
    if (sum_s >= N_EXT) begin
      idx = W'(sum_s - N_EXT);
    end else begin
      idx = sum_s[W-1:0];
    end
  end

endmodule : pri_rotate_enc

// File: rtl/pri_arbiter.sv
// Registered N-way arbiter with fixed-priority (MSB highest) or round-robin selection.
// A grant is held until the owner acks or withdraws its request; on release the next
// winner is loaded at the same edge with the released requester masked, so there are
// no bubbles while other requesters are waiting.
module pri_arbiter
  import pri_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         valid
);

  localparam logic [W-1:0] TOP_IDX    = W'(N - 1);
  localparam logic [N-1:0] ONE_HOT_B0 = {{(N-1){1'b0}}, 1'b1};

  // Pointer that follows a new winner: one below it, wrapping 0 to N-1.
  function automatic logic [W-1:0] next_ptr(input logic [W-1:0] winner);
    logic [W-1:0] res;
    if (winner == {W{1'b0}}) begin
      res = TOP_IDX;
    end else begin
      res = winner - {{(W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  arb_state_e   state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [W-1:0] idx_q, idx_d;
  logic         valid_q, valid_d;

  logic         release_s;   // current owner acked or dropped its request
  logic [N-1:0] enc_req_s;   // request vector seen by the encoder
  logic [W-1:0] start_s;     // first index examined by the encoder
  logic [W-1:0] win_idx_s;
  logic         win_found_s;

  // Encoder inputs: the current owner is masked out so a release hands over to someone else.
  always_comb begin
    if (state_q == ST_GRANT) begin
      enc_req_s = req & ~gnt_q;
    end else begin
      enc_req_s = req;
    end

    if (mode == MODE_RR) begin
      start_s = ptr_q;
    end else begin
      start_s = TOP_IDX;
    end

    // Ack and withdrawal together still count as a single release.
    if (state_q == ST_GRANT) begin
      release_s = ack | ~req[idx_q];
    end else begin
      release_s = 1'b0;
    end
  end

  pri_rotate_enc #(
    .N (N),
    .W (W)
  ) u_enc (
    .req   (enc_req_s),
    .start (start_s),
    .idx   (win_idx_s),
    .found (win_found_s)
  );

  // Next-state and next-output logic; defaults hold the current grant.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_GRANT;
          ptr_d   = next_ptr(win_idx_s);
          gnt_d   = ONE_HOT_B0 << win_idx_s;
          idx_d   = win_idx_s;
          valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = {N{1'b0}};
          idx_d   = {W{1'b0}};
          valid_d = 1'b0;
        end
      end

      ST_GRANT: begin
        if (!release_s) begin
          // Owner keeps the resource; mode and other requests are ignored.
          state_d = ST_GRANT;
        end else if (win_found_s) begin
          // Back-to-back handover to the next winner.
          state_d = ST_GRANT;
          ptr_d   = next_ptr(win_idx_s);
          gnt_d   = ONE_HOT_B0 << win_idx_s;
          idx_d   = win_idx_s;
          valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = {N{1'b0}};
          idx_d   = {W{1'b0}};
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ptr_d   = TOP_IDX;
        gnt_d   = {N{1'b0}};
        idx_d   = {W{1'b0}};
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= TOP_IDX;
      gnt_q   <= {N{1'b0}};
      idx_q   <= {W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign valid   = valid_q;

endmodule : pri_arbiter

// File: tb/tb_pri_arbiter.sv
// Directed scoreboard bench for pri_arbiter (N=8).
// The driver applies one input vector per cycle on the falling edge and queues the
// hand-computed output expected after the following rising edge; an independent
// monitor pops and compares just after each rising edge.
module tb_pri_arbiter;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         mode;
  logic         ack;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic         valid;

  typedef struct {
    logic [N-1:0] gnt;
    logic [W-1:0] idx;
    logic         valid;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;

  pri_arbiter #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mode    (mode),
    .ack     (ack),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .valid   (valid)
  );

  pri_arbiter_chk #(.N(N)) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the output expected after the next rising edge.
  task automatic step(input logic rn, input logic m, input logic [N-1:0] r, input logic a,
                      input logic [W-1:0] ei, input logic ev, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    mode  = m;
    req   = r;
    ack   = a;
    e.gnt   = ev ? (8'h01 << ei) : 8'h00;
    e.idx   = ev ? ei : 3'd0;
    e.valid = ev;
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (gnt !== e.gnt || gnt_idx !== e.idx || valid !== e.valid) begin
          n_errors++;
          $display("FAIL %s: got gnt=%h idx=%0d valid=%b, expected gnt=%h idx=%0d valid=%b",
                   e.name, gnt, gnt_idx, valid, e.gnt, e.idx, e.valid);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    mode  = 1'b0;
    req   = 8'hFF;
    ack   = 1'b0;

    // Reset holds everything at zero even with all requests asserted.
    step(1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, "reset_0");
    step(1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, "reset_1");
    step(1'b1, 1'b0, 8'hFF, 1'b0, 3'd7, 1'b1, "first_grant_fixed");

    // Fixed priority, req 6/4/1 with ack every cycle: 6,4,6,4 and 1 starves.
    step(1'b1, 1'b0, 8'b0101_0010, 1'b1, 3'd6, 1'b1, "fixed_a");
    step(1'b1, 1'b0, 8'b0101_0010, 1'b1, 3'd4, 1'b1, "fixed_b");
    step(1'b1, 1'b0, 8'b0101_0010, 1'b1, 3'd6, 1'b1, "fixed_c");
    step(1'b1, 1'b0, 8'b0101_0010, 1'b1, 3'd4, 1'b1, "fixed_d");

    // Withdraw everything to reach IDLE, then a fixed grant at 7 sets ptr=6.
    step(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "fixed_to_idle");
    step(1'b1, 1'b0, 8'hFF, 1'b0, 3'd7, 1'b1, "rr_seed_7");

    // Round-robin with all requesting and continuous ack: 6..0 then 7, no bubbles.
    step(1'b1, 1'b1, 8'hFF, 1'b1, 3'd6, 1'b1, "rr_6");
    step(1'b1, 1'b1, 8'hFF, 1'b1, 3'd5, 1'b1, "rr_5");
    step(1'b1, 1'b1, 8'hFF, 1'b1, 3'd4, 1'b1, "rr_4");
    step(1'b1, 1'b1, 8'hFF, 1'b1, 3'd3, 1'b1, "rr_3");
    step(1'b1, 1'b1, 8'hFF, 1'b1, 3'd2, 1'b1, "rr_2");
    step(1'b1, 1'b1, 8'hFF, 1'b1, 3'd1, 1'b1, "rr_1");
    step(1'b1, 1'b1, 8'hFF, 1'b1, 3'd0, 1'b1, "rr_0");
    step(1'b1, 1'b1, 8'hFF, 1'b1, 3'd7, 1'b1, "rr_wrap_7");

    // Withdrawal handovers: 7 drops -> 3, 3 drops -> 0, then empty -> IDLE.
    step(1'b1, 1'b1, 8'b0000_1000, 1'b0, 3'd3, 1'b1, "withdraw_to_3");
    step(1'b1, 1'b1, 8'b0000_0001, 1'b0, 3'd0, 1'b1, "withdraw_to_0");
    step(1'b1, 1'b1, 8'h00,        1'b0, 3'd0, 1'b0, "withdraw_empty");

    // Sole requester 2 with ack held high (also ignored while idle): bubble each grant.
    step(1'b1, 1'b0, 8'b0000_0100, 1'b1, 3'd2, 1'b1, "sole_on_a");
    step(1'b1, 1'b0, 8'b0000_0100, 1'b1, 3'd0, 1'b0, "sole_off_a");
    step(1'b1, 1'b0, 8'b0000_0100, 1'b1, 3'd2, 1'b1, "sole_on_b");
    step(1'b1, 1'b0, 8'b0000_0100, 1'b1, 3'd0, 1'b0, "sole_off_b");

    // Grant at 5 (ptr=4) held across a mode switch; the next winner comes from ptr=4.
    step(1'b1, 1'b0, 8'b0010_0000, 1'b0, 3'd5, 1'b1, "hold_grant_5");
    step(1'b1, 1'b1, 8'hFF,        1'b0, 3'd5, 1'b1, "hold_mode_switch_a");
    step(1'b1, 1'b1, 8'hFF,        1'b0, 3'd5, 1'b1, "hold_mode_switch_b");
    step(1'b1, 1'b1, 8'hFF,        1'b1, 3'd4, 1'b1, "rr_after_switch_4");

    // Round-robin down to 2 (ptr=1), reset drops it, first grant after reset is 7.
    step(1'b1, 1'b1, 8'hFF, 1'b1, 3'd3, 1'b1, "rr_pre_reset_3");
    step(1'b1, 1'b1, 8'hFF, 1'b1, 3'd2, 1'b1, "rr_pre_reset_2");
    step(1'b0, 1'b1, 8'hFF, 1'b1, 3'd0, 1'b0, "reset_mid_grant");
    step(1'b1, 1'b1, 8'hFF, 1'b0, 3'd7, 1'b1, "ptr_restored_7");

    // Ack plus withdrawal together is a single release: 7 -> 6, then empty.
    step(1'b1, 1'b1, 8'h7F, 1'b1, 3'd6, 1'b1, "ack_and_withdraw");
    step(1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, "final_idle");

    // Let the monitor consume the last expectation, then confirm nothing is left over.
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pri_arbiter
